// File: rtl/multi_roi_color_tracker.sv
// multi_roi_color_tracker: per-region RGB pixel classification and counting, a dominant
// colour per region at each frame end, and N-frame debouncing of that result
module multi_roi_color_tracker #(
   parameter int NUM_ROI = 4,
   parameter int PIX_W = 8,
   parameter int CNT_W = 16,
   parameter logic [10*NUM_ROI-1:0] ROI_X_START = {NUM_ROI{10'd0}},
   parameter logic [10*NUM_ROI-1:0] ROI_X_END = {NUM_ROI{10'd0}},
   parameter logic [10*NUM_ROI-1:0] ROI_Y_START = {NUM_ROI{10'd0}},
   parameter logic [10*NUM_ROI-1:0] ROI_Y_END = {NUM_ROI{10'd0}},
   parameter int HI_TH = 180,
   parameter int LO_TH = 100,
   parameter int MIN_PIXELS = 100,
   parameter int STABLE_FRAMES = 3
) (
   input logic clk,
   input logic reset,
   input logic enable,
   input logic pixel_valid,
   input logic frame_end,
   input logic [9:0] x_coord,
   input logic [9:0] y_coord,
   input logic [PIX_W-1:0] pixel_r,
   input logic [PIX_W-1:0] pixel_g,
   input logic [PIX_W-1:0] pixel_b,
   output logic [NUM_ROI-1:0] in_roi,
   output logic [2*NUM_ROI-1:0] raw_color,
   output logic [2*NUM_ROI-1:0] stable_color,
   output logic [NUM_ROI-1:0] changed,
   output logic result_valid,
   output logic busy,
   output logic overrun
);
   typedef enum logic [1:0] {ACCUM, SNAP, EVAL, UPDATE} state_t;
   localparam int IW = NUM_ROI > 1 ? $clog2(NUM_ROI) : 1;
   localparam logic [PIX_W-1:0] HI = PIX_W'(HI_TH);
   localparam logic [PIX_W-1:0] LO = PIX_W'(LO_TH);
   localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PIXELS);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [3:0] SF = 4'(STABLE_FRAMES);

   state_t state, state_n;
   logic [1:0] cls, cls_q, win;
   logic [NUM_ROI-1:0] hit, chg_n;
   logic fe1, clr;
   logic [IW-1:0] idx;
   logic [CNT_W-1:0] cnt [NUM_ROI][3];
   logic [CNT_W-1:0] shd [NUM_ROI][3];
   logic [CNT_W-1:0] cr, cg, cb;
   logic [2*NUM_ROI-1:0] raw_w, cand, stab_n;
   logic [4*NUM_ROI-1:0] run, run_n;

   always_comb begin
      cls = (pixel_r >= HI && pixel_g <= LO && pixel_b <= LO) ? 2'd1
          : (pixel_g >= HI && pixel_r <= LO && pixel_b <= LO) ? 2'd2
          : (pixel_b >= HI && pixel_r <= LO && pixel_g <= LO) ? 2'd3 : 2'd0;
      hit = '0;
      for (int i = 0; i < NUM_ROI; i++)
         hit[i] = x_coord >= ROI_X_START[10*i +: 10] && x_coord <= ROI_X_END[10*i +: 10]
               && y_coord >= ROI_Y_START[10*i +: 10] && y_coord <= ROI_Y_END[10*i +: 10];
   end

   always_ff @(posedge clk)
      if (!reset) begin
         cls_q <= 2'd0;
         in_roi <= '0;
      end else begin
         cls_q <= (pixel_valid && enable) ? cls : 2'd0;
         in_roi <= (pixel_valid && enable) ? hit : '0;
      end

   always_ff @(posedge clk)
      if (!reset) state <= ACCUM;
      else state <= state_n;

   always_comb
      state_n = state == ACCUM ? (fe1 ? SNAP : ACCUM)
              : state == SNAP ? EVAL
              : state == EVAL ? (idx == IW'(NUM_ROI-1) ? UPDATE : EVAL)
              : ACCUM;

   always_comb begin
      busy = state != ACCUM;
      clr = state == SNAP || overrun;
   end

   // a discarded frame clears live counts on the overrun cycle, mirroring the SNAP-cycle clear
   always_ff @(posedge clk)
      if (!reset) begin
         for (int i = 0; i < NUM_ROI; i++)
            for (int j = 0; j < 3; j++) begin
               cnt[i][j] <= '0;
               shd[i][j] <= '0;
            end
      end else begin
         for (int i = 0; i < NUM_ROI; i++)
            for (int j = 0; j < 3; j++) begin
               if (state == SNAP) shd[i][j] <= cnt[i][j];
               if (in_roi[i] && cls_q == 2'(j+1))
                  cnt[i][j] <= clr ? CNT_W'(1) : (cnt[i][j] == CMAX ? CMAX : cnt[i][j] + 1'b1);
               else if (clr)
                  cnt[i][j] <= '0;
            end
      end

   always_comb begin
      cr = shd[idx][0];
      cg = shd[idx][1];
      cb = shd[idx][2];
      win = (cr > cg && cr > cb && cr >= MINP) ? 2'd1
          : (cg > cr && cg > cb && cg >= MINP) ? 2'd2
          : (cb > cr && cb > cg && cb >= MINP) ? 2'd3 : 2'd0;
   end

   // the new candidate always equals the raw result, so raw_w doubles as cand_next
   always_comb begin
      stab_n = stable_color;
      chg_n = '0;
      run_n = '0;
      for (int i = 0; i < NUM_ROI; i++) begin
         run_n[4*i +: 4] = raw_w[2*i +: 2] != cand[2*i +: 2] ? 4'd1
                         : run[4*i +: 4] == SF ? SF : run[4*i +: 4] + 4'd1;
         if (run_n[4*i +: 4] == SF && raw_w[2*i +: 2] != stable_color[2*i +: 2]) begin
            stab_n[2*i +: 2] = raw_w[2*i +: 2];
            chg_n[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk)
      if (!reset) begin
         fe1 <= 1'b0;
         overrun <= 1'b0;
         idx <= '0;
         raw_w <= '0;
         cand <= '0;
         run <= '0;
         raw_color <= '0;
         stable_color <= '0;
         changed <= '0;
         result_valid <= 1'b0;
      end else begin
         fe1 <= frame_end && enable;
         overrun <= fe1 && state != ACCUM;
         idx <= state == EVAL ? idx + 1'b1 : '0;
         if (state == EVAL) raw_w[2*idx +: 2] <= win;
         result_valid <= state == UPDATE;
         changed <= state == UPDATE ? chg_n : '0;
         if (state == UPDATE) begin
            raw_color <= raw_w;
            stable_color <= stab_n;
            cand <= raw_w;
            run <= run_n;
         end
      end
endmodule

// File: tb/tb_multi_roi_color_tracker.sv
// tb_multi_roi_color_tracker: directed checks of classification, counting, evaluation,
// debouncing, overrun and reset on two tracker instances sharing one stimulus
module tb_multi_roi_color_tracker;
   localparam logic [19:0] XS = {10'd200, 10'd100};
   localparam logic [19:0] XE = {10'd299, 10'd219};
   localparam logic [19:0] YS = {10'd150, 10'd60};
   localparam logic [19:0] YE = {10'd249, 10'd179};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b1;
   logic pixel_valid = 1'b0;
   logic frame_end = 1'b0;
   logic [9:0] x_coord = '0;
   logic [9:0] y_coord = '0;
   logic [7:0] pixel_r = '0;
   logic [7:0] pixel_g = '0;
   logic [7:0] pixel_b = '0;
   logic [1:0] a_in_roi, a_changed, b_in_roi, b_changed;
   logic [3:0] a_raw, a_stable, b_raw, b_stable;
   logic a_rv, a_busy, a_ovr, b_rv, b_busy, b_ovr;
   int tests = 0;
   int fails = 0;
   int lat;

   always #5 clk = ~clk;

   multi_roi_color_tracker #(
      .NUM_ROI(2), .ROI_X_START(XS), .ROI_X_END(XE), .ROI_Y_START(YS), .ROI_Y_END(YE)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .pixel_valid(pixel_valid), .frame_end(frame_end),
      .x_coord(x_coord), .y_coord(y_coord), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
      .in_roi(a_in_roi), .raw_color(a_raw), .stable_color(a_stable), .changed(a_changed),
      .result_valid(a_rv), .busy(a_busy), .overrun(a_ovr)
   );

   multi_roi_color_tracker #(
      .NUM_ROI(2), .CNT_W(8), .STABLE_FRAMES(1),
      .ROI_X_START(XS), .ROI_X_END(XE), .ROI_Y_START(YS), .ROI_Y_END(YE)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .pixel_valid(pixel_valid), .frame_end(frame_end),
      .x_coord(x_coord), .y_coord(y_coord), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
      .in_roi(b_in_roi), .raw_color(b_raw), .stable_color(b_stable), .changed(b_changed),
      .result_valid(b_rv), .busy(b_busy), .overrun(b_ovr)
   );

   task automatic do_reset();
      reset = 1'b0;
      enable = 1'b1;
      pixel_valid = 1'b0;
      frame_end = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic pix(input int n, input logic [9:0] px, input logic [9:0] py,
                      input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
      pixel_valid = 1'b1;
      x_coord = px;
      y_coord = py;
      pixel_r = pr;
      pixel_g = pg;
      pixel_b = pb;
      repeat (n) @(posedge clk);
      #1 pixel_valid = 1'b0;
   endtask

   // pulses frame_end in cycle T and returns once result_valid is seen; lat is then 6 for T+6
   task automatic fend();
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      lat = 1;
      while (!a_rv && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({a_in_roi, a_raw, a_stable, a_changed, a_rv, a_busy, a_ovr} !== 15'd0) begin
         fails++;
         $display("FAIL reset_a got %b exp 0", {a_in_roi, a_raw, a_stable, a_changed, a_rv, a_busy, a_ovr});
      end
      tests++;
      if ({b_in_roi, b_raw, b_stable, b_changed, b_rv, b_busy, b_ovr} !== 15'd0) begin
         fails++;
         $display("FAIL reset_b got %b exp 0", {b_in_roi, b_raw, b_stable, b_changed, b_rv, b_busy, b_ovr});
      end
      reset = 1'b1;
   endtask

   task automatic test_in_roi();
      logic [9:0] xs [6] = '{10'd210, 10'd100, 10'd250, 10'd220, 10'd99, 10'd100};
      logic [9:0] ys [6] = '{10'd160, 10'd179, 10'd200, 10'd60, 10'd60, 10'd60};
      logic [1:0] ex [6] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         pixel_valid = i < 5;
         x_coord = xs[i];
         y_coord = ys[i];
         @(posedge clk);
         #1;
         tests++;
         if (a_in_roi !== ex[i]) begin
            fails++;
            $display("FAIL in_roi[%0d] got %b exp %b", i, a_in_roi, ex[i]);
         end
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_debounce();
      do_reset();
      for (int f = 1; f <= 3; f++) begin
         pix(f == 1 ? 14400 : 150, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
         pix(10, 10'd0, 10'd0, 8'd0, 8'd0, 8'd0);
         fend();
         tests++;
         if (lat !== 6) begin fails++; $display("FAIL deb_latency f%0d got %0d exp 6", f, lat); end
         tests++;
         if (a_raw !== 4'b0001) begin fails++; $display("FAIL deb_raw f%0d got %b exp 0001", f, a_raw); end
         tests++;
         if (a_stable !== (f == 3 ? 4'b0001 : 4'b0000)) begin
            fails++;
            $display("FAIL deb_stable f%0d got %b exp %b", f, a_stable, f == 3 ? 4'b0001 : 4'b0000);
         end
         tests++;
         if (a_changed !== (f == 3 ? 2'b01 : 2'b00)) begin
            fails++;
            $display("FAIL deb_changed f%0d got %b exp %b", f, a_changed, f == 3 ? 2'b01 : 2'b00);
         end
         if (f == 1) begin
            tests++;
            if ({b_stable, b_changed} !== 6'b0001_01) begin
               fails++;
               $display("FAIL deb_b_f1 got %b exp 000101", {b_stable, b_changed});
            end
         end
         @(posedge clk);
         #1;
         tests++;
         if ({a_rv, a_changed} !== 3'b000) begin
            fails++;
            $display("FAIL deb_strobe_len f%0d got %b exp 000", f, {a_rv, a_changed});
         end
      end
      tests++;
      if (a_stable !== 4'b0001) begin fails++; $display("FAIL deb_hold got %b exp 0001", a_stable); end
   endtask

   task automatic test_threshold();
      do_reset();
      pix(120, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      pix(120, 10'd100, 10'd60, 8'd50, 8'd200, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0000) begin fails++; $display("FAIL tie got %b exp 0000", a_raw); end
      pix(99, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0000) begin fails++; $display("FAIL below_min got %b exp 0000", a_raw); end
      pix(100, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0001) begin fails++; $display("FAIL at_min got %b exp 0001", a_raw); end
      pix(150, 10'd100, 10'd60, 8'd50, 8'd50, 8'd200);
      pix(150, 10'd100, 10'd60, 8'd200, 8'd110, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0011) begin fails++; $display("FAIL blue_vs_noclass got %b exp 0011", a_raw); end
   endtask

   task automatic test_alternate();
      logic [1:0] col;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         col = f[0] ? 2'b10 : 2'b01;
         pix(150, 10'd100, 10'd60, f[0] ? 8'd50 : 8'd200, f[0] ? 8'd200 : 8'd50, 8'd50);
         fend();
         tests++;
         if ({a_raw, a_stable, a_changed} !== {2'b00, col, 6'b0}) begin
            fails++;
            $display("FAIL alt_a f%0d got %b exp %b", f, {a_raw, a_stable, a_changed}, {2'b00, col, 6'b0});
         end
         tests++;
         if ({b_stable, b_changed} !== {2'b00, col, 2'b01}) begin
            fails++;
            $display("FAIL alt_b f%0d got %b exp %b", f, {b_stable, b_changed}, {2'b00, col, 2'b01});
         end
      end
   endtask

   task automatic test_overlap_saturate();
      do_reset();
      pix(150, 10'd210, 10'd160, 8'd200, 8'd50, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0101) begin fails++; $display("FAIL overlap got %b exp 0101", a_raw); end
      pix(300, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      pix(100, 10'd100, 10'd60, 8'd50, 8'd200, 8'd50);
      fend();
      tests++;
      if (b_raw !== 4'b0001) begin fails++; $display("FAIL saturate_b got %b exp 0001", b_raw); end
      tests++;
      if (a_raw !== 4'b0001) begin fails++; $display("FAIL saturate_a got %b exp 0001", a_raw); end
   endtask

   task automatic test_overrun();
      int n;
      do_reset();
      pix(150, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      pixel_valid = 1'b1;
      pixel_g = 8'd200;
      pixel_r = 8'd50;
      repeat (2) @(posedge clk);
      #1 frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      pixel_valid = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({a_ovr, a_rv} !== 2'b10) begin fails++; $display("FAIL ovr_pulse got %b exp 10", {a_ovr, a_rv}); end
      @(posedge clk);
      #1;
      tests++;
      if ({a_ovr, a_rv, a_raw} !== 6'b01_0001) begin
         fails++;
         $display("FAIL ovr_result got %b exp 010001", {a_ovr, a_rv, a_raw});
      end
      n = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (a_rv) n++;
      end
      tests++;
      if (n !== 0) begin fails++; $display("FAIL ovr_extra_results got %0d exp 0", n); end
      pix(99, 10'd100, 10'd60, 8'd50, 8'd200, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0000) begin fails++; $display("FAIL ovr_restart got %b exp 0000", a_raw); end
   endtask

   task automatic test_enable();
      int n;
      do_reset();
      enable = 1'b0;
      pix(200, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1 if (a_rv || a_busy) n++;
      end
      tests++;
      if (n !== 0) begin fails++; $display("FAIL en_ignore_fe got %0d exp 0", n); end
      enable = 1'b1;
      pix(99, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      fend();
      tests++;
      if (a_raw !== 4'b0000) begin fails++; $display("FAIL en_no_count got %b exp 0000", a_raw); end
   endtask

   task automatic test_reset_eval();
      int n;
      do_reset();
      pix(150, 10'd100, 10'd60, 8'd200, 8'd50, 8'd50);
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (a_busy !== 1'b1) begin fails++; $display("FAIL rst_eval_busy got %b exp 1", a_busy); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({a_in_roi, a_raw, a_stable, a_changed, a_rv, a_busy, a_ovr} !== 15'd0) begin
         fails++;
         $display("FAIL rst_eval_outs got %b exp 0", {a_in_roi, a_raw, a_stable, a_changed, a_rv, a_busy, a_ovr});
      end
      reset = 1'b1;
      n = 0;
      repeat (10) begin
         @(posedge clk);
         #1 if (a_rv) n++;
      end
      tests++;
      if (n !== 0) begin fails++; $display("FAIL rst_eval_result got %0d exp 0", n); end
      pix(150, 10'd100, 10'd60, 8'd50, 8'd200, 8'd50);
      fend();
      tests++;
      if ({lat[3:0], a_raw} !== 8'h62) begin
         fails++;
         $display("FAIL rst_eval_clean got lat %0d raw %b exp lat 6 raw 0010", lat, a_raw);
      end
   endtask

   initial begin
      test_reset();
      test_in_roi();
      test_debounce();
      test_threshold();
      test_alternate();
      test_overlap_saturate();
      test_overrun();
      test_enable();
      test_reset_eval();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
